zynet_inference_sequencer: RTL and testbench

Control FSM that sequences one zyNet inference at a time. Admits an input frame from upstream into the input serializer, pulses the network `start`, and waits for the network result. It captures the `OUTPUT_LAYER_HEIGHT`-word result vector and holds it for a downstream consumer with a frame ID. It sits between the frame source, the `fc_output_layer` input serializer, `zyNet`, and the result sink.

---
 rtl/zynet_inference_sequencer.sv | 146 ++++++++++++++
 tb/tb_zynet_inference_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zynet_inference_sequencer.sv
// One-frame-at-a-time control sequencer for zyNet: admit frame, pulse start, capture and hold the result.
// Optional BUSY watchdog abort is built when ZYNET_SEQ_WATCHDOG_EN is defined.
module zynet_inference_sequencer #(
   parameter int OUTPUT_LAYER_HEIGHT = 10,
   parameter int WORD_SIZE           = 16,
   parameter int ID_WIDTH            = 8,
   parameter int TIMEOUT_CYCLES      = 4096
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic                                      req_valid_i,
   output logic                                      req_ready_o,
   output logic                                      ser_valid_o,
   input  logic                                      ser_ready_i,
   output logic                                      start_o,
   input  logic                                      net_valid_i,
   input  logic [OUTPUT_LAYER_HEIGHT*WORD_SIZE-1:0]  net_data_i,
   output logic                                      net_yumi_o,
   output logic                                      res_valid_o,
   output logic [OUTPUT_LAYER_HEIGHT*WORD_SIZE-1:0]  res_data_o,
   output logic [ID_WIDTH-1:0]                       res_id_o,
   output logic                                      res_timeout_o,
   input  logic                                      res_yumi_i,
   output logic                                      busy_o
);

   localparam int RES_W = OUTPUT_LAYER_HEIGHT * WORD_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_BUSY,
      ST_OUTPUT
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [RES_W-1:0]    res_data_q;
   logic [ID_WIDTH-1:0] frame_id_q;
   logic                capture;
   logic                abort;
   logic                consume;
   logic                expire;

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      ser_valid_o = 1'b0;
      start_o     = 1'b0;
      net_yumi_o  = 1'b0;
      res_valid_o = 1'b0;
      capture     = 1'b0;
      abort       = 1'b0;
      consume     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ser_valid_o = req_valid_i;
            req_ready_o = ser_ready_i;
            if (req_valid_i && ser_ready_i) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            start_o = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            net_yumi_o = net_valid_i;
            // A result arriving on the expiry cycle takes priority over the abort.
            if (net_valid_i) begin
               capture = 1'b1;
               state_d = ST_OUTPUT;
            end else if (expire) begin
               abort   = 1'b1;
               state_d = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            res_valid_o = 1'b1;
            if (res_yumi_i) begin
               consume = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         frame_id_q <= '0;
         res_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (consume) begin
            frame_id_q <= frame_id_q + ID_WIDTH'(1);
         end
         if (capture) begin
            res_data_q <= net_data_i;
         end else if (abort) begin
            res_data_q <= '0;
         end
      end
   end

`ifdef ZYNET_SEQ_WATCHDOG_EN
   localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              res_timeout_q;

   assign expire = (state_q == ST_BUSY) && (wdog_cnt_q == WDOG_W'(TIMEOUT_CYCLES - 1));

   // START is the single cycle before BUSY entry, so clearing there zeroes the count on entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wdog_cnt_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_START) begin
            wdog_cnt_q <= '0;
         end else if (state_q == ST_BUSY) begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
         end
         if (capture) begin
            res_timeout_q <= 1'b0;
         end else if (abort) begin
            res_timeout_q <= 1'b1;
         end
      end
   end

   assign res_timeout_o = res_valid_o & res_timeout_q;
`else
   assign expire        = 1'b0;
   assign res_timeout_o = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   assign res_data_o = res_data_q;
   assign res_id_o   = frame_id_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zynet_inference_sequencer.sv
// Self-checking bench for zynet_inference_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the frame handshake rules.
module tb_zynet_inference_sequencer;

   localparam int H     = 10;
   localparam int WS    = 16;
   localparam int IDW   = 8;
   localparam int TMO   = 16;
   localparam int RES_W = H * WS;
`ifdef ZYNET_SEQ_WATCHDOG_EN
   localparam bit WDOG    = 1'b1;
   localparam int NET_LAT = 10;
`else
   localparam bit WDOG    = 1'b0;
   localparam int NET_LAT = 20;
`endif

   logic             clk = 1'b0;
   logic             reset_i = 1'b1;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic             ser_valid_o;
   logic             ser_ready_i = 1'b0;
   logic             start_o;
   logic             net_valid_i = 1'b0;
   logic [RES_W-1:0] net_data_i = '0;
   logic             net_yumi_o;
   logic             res_valid_o;
   logic [RES_W-1:0] res_data_o;
   logic [IDW-1:0]   res_id_o;
   logic             res_timeout_o;
   logic             res_yumi_i = 1'b0;
   logic             busy_o;

   zynet_inference_sequencer #(
      .OUTPUT_LAYER_HEIGHT(H),
      .WORD_SIZE(WS),
      .ID_WIDTH(IDW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .ser_valid_o(ser_valid_o),
      .ser_ready_i(ser_ready_i),
      .start_o(start_o),
      .net_valid_i(net_valid_i),
      .net_data_i(net_data_i),
      .net_yumi_o(net_yumi_o),
      .res_valid_o(res_valid_o),
      .res_data_o(res_data_o),
      .res_id_o(res_id_o),
      .res_timeout_o(res_timeout_o),
      .res_yumi_i(res_yumi_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RES_W-1:0] rand_vec();
      logic [RES_W-1:0] v;
      for (int i = 0; i < RES_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      req_valid_i = 1'b1;
      ser_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
   endtask

   // Model: phase 0 waiting for a frame, 1 start cycle, 2 network running, 3 result held.
   bit               model_on = 1'b0;
   int               phase = 0;
   int               acc_cnt = 0;
   int               wcnt = 0;
   int               n_start = 0;
   int               n_cons = 0;
   int               last_id = -1;
   logic [RES_W-1:0] exp_data = '0;
   logic [IDW-1:0]   exp_id = '0;
   logic             exp_to = 1'b0;
   logic [6:0]       exp_ctl;
   logic [6:0]       got_ctl;

   always @(negedge clk) begin
      if (model_on) begin
         got_ctl = {req_ready_o, ser_valid_o, start_o, net_yumi_o, res_valid_o, res_timeout_o, busy_o};
         case (phase)
            0:       exp_ctl = {ser_ready_i, req_valid_i, 5'b00000};
            1:       exp_ctl = 7'b0010001;
            2:       exp_ctl = {3'b000, net_valid_i, 3'b001};
            default: exp_ctl = {4'b0000, 1'b1, exp_to, 1'b1};
         endcase
         check("ctl", got_ctl, exp_ctl);
         if (phase == 3) begin
            check("res_data", res_data_o, exp_data);
            check("res_id", res_id_o, exp_id);
         end
         if (start_o) n_start++;
         if (reset_i) begin
            phase   = 0;
            acc_cnt = 0;
         end else begin
            case (phase)
               0: if (req_valid_i && ser_ready_i) begin
                  exp_id  = IDW'(acc_cnt % 256);
                  acc_cnt = acc_cnt + 1;
                  phase   = 1;
               end
               1: begin
                  wcnt  = 0;
                  phase = 2;
               end
               2: if (net_valid_i) begin
                  exp_data = net_data_i;
                  exp_to   = 1'b0;
                  phase    = 3;
               end else if (WDOG && wcnt == TMO - 1) begin
                  exp_data = '0;
                  exp_to   = 1'b1;
                  phase    = 3;
               end else begin
                  wcnt = wcnt + 1;
               end
               default: if (res_yumi_i) begin
                  n_cons++;
                  last_id = int'(exp_id);
                  phase   = 0;
               end
            endcase
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      logic [RES_W-1:0] pat;
      logic [RES_W-1:0] v;
      int s0;
      int c0;

      for (int j = 0; j < H; j++) pat[j*WS +: WS] = WS'(j + 1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      model_on    = 1'b1;
      ser_ready_i = 1'b1;
      @(negedge clk);
      check("rst_data", res_data_o, '0);
      check("rst_id", res_id_o, 0);
      check("rst_busy", busy_o, 0);
      tick();
      reset_i = 1'b0;

      // Single frame, network answers after NET_LAT cycles
      start_frame();
      repeat (NET_LAT) tick();
      net_valid_i = 1'b1;
      net_data_i  = pat;
      tick();
      net_valid_i = 1'b0;
      net_data_i  = rand_vec();
      @(negedge clk);
      check("f0_valid", res_valid_o, 1);
      check("f0_data", res_data_o, pat);
      check("f0_id", res_id_o, 0);
      check("f0_starts", n_start, 1);
      tick();

      // Result back-pressure with a frame waiting upstream
      req_valid_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("hold_valid", res_valid_o, 1);
         check("hold_data", res_data_o, pat);
         check("hold_gate", {req_ready_o, ser_valid_o}, 2'b00);
         tick();
      end
      check("hold_starts", n_start, 1);
      req_valid_i = 1'b0;
      res_yumi_i  = 1'b1;
      tick();
      res_yumi_i = 1'b0;
      @(negedge clk);
      check("after_consume_busy", busy_o, 0);
      check("after_consume_id", res_id_o, 1);
      tick();

      // Randomized back-to-back traffic
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      s0 = n_start;
      c0 = n_cons;
      for (int c = 0; c < 20000 && (n_cons - c0) < 300; c++) begin
         req_valid_i = (acc_cnt < 300) && ($urandom_range(3) != 0);
         ser_ready_i = ($urandom_range(2) != 0);
         res_yumi_i  = ($urandom_range(2) != 0);
         net_valid_i = ($urandom_range(3) == 0);
         net_data_i  = rand_vec();
         tick();
      end
      req_valid_i = 1'b0;
      res_yumi_i  = 1'b0;
      net_valid_i = 1'b0;
      ser_ready_i = 1'b1;
      check("rand_results", n_cons - c0, 300);
      check("rand_starts", n_start - s0, 300);
      check("rand_last_id", last_id, 43);
      tick();

      // Reset while the network is running, then a stray result in IDLE
      start_frame();
      tick();
      reset_i = 1'b1;
      @(negedge clk);
      check("pre_rst_busy", busy_o, 1);
      tick();
      reset_i     = 1'b0;
      net_valid_i = 1'b1;
      @(negedge clk);
      check("rst_busy_idle", busy_o, 0);
      check("rst_busy_rv", res_valid_o, 0);
      check("stray_yumi", net_yumi_o, 0);
      tick();
      net_valid_i = 1'b0;

      // Reset while a result is held
      start_frame();
      tick();
      net_valid_i = 1'b1;
      net_data_i  = rand_vec();
      tick();
      net_valid_i = 1'b0;
      reset_i     = 1'b1;
      @(negedge clk);
      check("pre_rst_rv", res_valid_o, 1);
      tick();
      reset_i = 1'b0;
      @(negedge clk);
      check("rst_out_rv", res_valid_o, 0);
      check("rst_out_data", res_data_o, '0);
      check("rst_out_busy", busy_o, 0);
      tick();
      start_frame();
      tick();
      v           = rand_vec();
      net_valid_i = 1'b1;
      net_data_i  = v;
      tick();
      net_valid_i = 1'b0;
      @(negedge clk);
      check("post_rst_id", res_id_o, 0);
      check("post_rst_data", res_data_o, v);
      tick();
      res_yumi_i = 1'b1;
      tick();
      res_yumi_i = 1'b0;

`ifdef ZYNET_SEQ_WATCHDOG_EN
      // Silent network: abort result 16 cycles after BUSY entry
      start_frame();
      tick();
      repeat (15) tick();
      @(negedge clk);
      check("wd_early_rv", res_valid_o, 0);
      tick();
      @(negedge clk);
      check("wd_rv", res_valid_o, 1);
      check("wd_to", res_timeout_o, 1);
      check("wd_data", res_data_o, '0);
      check("wd_id", res_id_o, 1);
      tick();
      res_yumi_i = 1'b1;
      tick();
      res_yumi_i = 1'b0;

      // Result arriving on the expiry cycle wins
      start_frame();
      tick();
      repeat (15) tick();
      v           = rand_vec();
      net_valid_i = 1'b1;
      net_data_i  = v;
      tick();
      net_valid_i = 1'b0;
      @(negedge clk);
      check("wd_race_rv", res_valid_o, 1);
      check("wd_race_to", res_timeout_o, 0);
      check("wd_race_data", res_data_o, v);
      check("wd_race_id", res_id_o, 2);
      tick();
      res_yumi_i = 1'b1;
      tick();
      res_yumi_i = 1'b0;
`endif

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
